// File: rtl/udp_tpg_pkg.sv
// Shared definitions for the UDP test-pattern generator and its downstream frame checker.
package udp_tpg_pkg;

    localparam int HDR_BYTES = 8;
    localparam int LEN_POS   = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_SKIP = 2'd3
    } chk_state_t;

    localparam int ERR_HDR  = 0;
    localparam int ERR_LEN  = 1;
    localparam int ERR_PAY  = 2;
    localparam int ERR_BITS = 3;

    // Header byte at position 0..7 of {header0, header1, type, length}, MSB first.
    function automatic logic [7:0] hdr_byte(input logic [2:0] pos, input logic [15:0] h0,
                                            input logic [15:0] h1, input logic [15:0] ty,
                                            input logic [15:0] len);
        logic [15:0] w;
        case (pos[2:1])
            2'd0:    w = h0;
            2'd1:    w = h1;
            2'd2:    w = ty;
            default: w = len;
        endcase
        return pos[0] ? w[7:0] : w[15:8];
    endfunction

endpackage

// File: rtl/udp_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clr wins over inc.
module udp_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/udp_tpg_frame_checker.sv
// Checks header, length and index-pattern payload of each valid run from the UDP pattern source.
module udp_tpg_frame_checker
    import udp_tpg_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chk_enable,
    input  logic             chk_clear,
    input  logic [15:0]      exp_header0,
    input  logic [15:0]      exp_header1,
    input  logic [15:0]      exp_type,
    input  logic [15:0]      exp_length,
    input  logic [15:0]      exp_num,
    input  logic [7:0]       rx_data,
    input  logic             rx_data_valid,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             hdr_err,
    output logic             len_err,
    output logic             pay_err,
    output logic             all_done
);

    chk_state_t          state, state_nxt;
    logic [IDX_W-1:0]    index, cur_idx;
    logic [ERR_BITS-1:0] frm_err, byte_err, close_err;
    logic [7:0]          exp_byte;
    logic [15:0]         rx_len;
    logic                idx_ovf, started, accept, close, run_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // A run already in flight (after reset, or while disabled) is skipped, never half-checked.
    always_comb begin
        state_nxt = state;
        if (chk_clear) begin
            state_nxt = rx_data_valid ? ST_SKIP : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (rx_data_valid) state_nxt = (chk_enable && started) ? ST_HDR : ST_SKIP;
                ST_HDR, ST_PAY: begin
                    if (!chk_enable)        state_nxt = rx_data_valid ? ST_SKIP : ST_IDLE;
                    else if (!rx_data_valid) state_nxt = ST_IDLE;
                    else if (state == ST_HDR && index == IDX_W'(HDR_BYTES - 1)) state_nxt = ST_PAY;
                end
                default: if (!rx_data_valid) state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        accept    = 1'b0;
        close     = 1'b0;
        cur_idx   = index;
        byte_err  = '0;
        case (state)
            ST_IDLE: begin
                cur_idx = '0;
                accept  = rx_data_valid && chk_enable && started;
            end
            ST_HDR, ST_PAY: begin
                accept = rx_data_valid && chk_enable;
                close  = !rx_data_valid && chk_enable;
            end
            default: ;
        endcase
        if (chk_clear) begin
            accept = 1'b0;
            close  = 1'b0;
        end
        // Payload byte is (index-8)[7:0]; only the low 8 bits of the subtraction matter.
        if (cur_idx < IDX_W'(HDR_BYTES))
            exp_byte = hdr_byte(cur_idx[2:0], exp_header0, exp_header1, exp_type, exp_length);
        else
            exp_byte = cur_idx[7:0] - 8'(HDR_BYTES);
        if (rx_data != exp_byte) begin
            if (cur_idx < IDX_W'(LEN_POS))        byte_err[ERR_HDR] = 1'b1;
            else if (cur_idx < IDX_W'(HDR_BYTES)) byte_err[ERR_LEN] = 1'b1;
            else                                  byte_err[ERR_PAY] = 1'b1;
        end
        run_bad = idx_ovf || (32'(index) < HDR_BYTES) || (32'(index) != 32'(rx_len) + HDR_BYTES);
        close_err          = frm_err;
        close_err[ERR_LEN] = frm_err[ERR_LEN] | run_bad;
    end

    // index holds the run length so far; idx_ovf marks a run that outgrew the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index   <= '0;
            frm_err <= '0;
            idx_ovf <= 1'b0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (accept) begin
                if (state == ST_IDLE) begin
                    index   <= IDX_W'(1);
                    frm_err <= byte_err;
                    idx_ovf <= 1'b0;
                end else begin
                    frm_err <= frm_err | byte_err;
                    if (index == '1) idx_ovf <= 1'b1;
                    else             index   <= index + 1'b1;
                end
            end else begin
                index   <= '0;
                frm_err <= '0;
                idx_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && cur_idx == IDX_W'(LEN_POS))     rx_len[15:8] <= rx_data;
        if (accept && cur_idx == IDX_W'(LEN_POS + 1)) rx_len[7:0]  <= rx_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            hdr_err    <= 1'b0;
            len_err    <= 1'b0;
            pay_err    <= 1'b0;
        end else begin
            frame_done <= close;
            frame_ok   <= close && (close_err == '0);
            if (chk_clear) begin
                hdr_err <= 1'b0;
                len_err <= 1'b0;
                pay_err <= 1'b0;
            end else if (close) begin
                hdr_err <= hdr_err | close_err[ERR_HDR];
                len_err <= len_err | close_err[ERR_LEN];
                pay_err <= pay_err | close_err[ERR_PAY];
            end
        end
    end

    udp_sat_counter #(.CNT_W(CNT_W)) u_ok_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (close && (close_err == '0)),
        .clr     (chk_clear),
        .count   (ok_cnt)
    );

    udp_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (close && (close_err != '0)),
        .clr     (chk_clear),
        .count   (err_cnt)
    );

    assign all_done = (exp_num != '0) && (32'(ok_cnt) + 32'(err_cnt) == 32'(exp_num));

endmodule
